// File: rtl/multicycle_control_unit_if.sv
// Bundles the control unit's opcode/handshake inputs and datapath control outputs.
// The datapath side uses master; the control unit uses slave.
interface multicycle_control_unit_if #(
  parameter int OPW   = 4,
  parameter int CNT_W = 24
);
  logic [OPW-1:0]   Opcode;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic [1:0]       PCSource;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemToReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [3:0]       State;
  logic             Halted;
  logic             Fault;
  logic [CNT_W-1:0] Retired;

  modport master (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, State,
           Halted, Fault, Retired
  );

  modport slave (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, State,
           Halted, Fault, Retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control FSM for the datapath: fetch/decode/execute/memory/writeback,
// memory wait states with timeout, halt/fault sinks and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int          OPW         = 4,
  parameter int          CNT_W       = 24,
  parameter int          MEM_TIMEOUT = 16,
  parameter int unsigned OP_RTYPE    = 0,
  parameter int unsigned OP_ADDI     = 1,
  parameter int unsigned OP_LW       = 2,
  parameter int unsigned OP_SW       = 3,
  parameter int unsigned OP_BEQ      = 4,
  parameter int unsigned OP_J        = 5,
  parameter int unsigned OP_HALT     = 15
) (
  input logic                     Clock,
  input logic                     Reset_n,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_RWB      = 4'd8,
    S_EXEC_I   = 4'd9,
    S_IWB      = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             in_wait, timeout, retire;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout = !bus.MemReady && (wait_q == TO_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
                  else if (timeout) state_d = S_FAULT;
      S_DECODE: begin
        case (bus.Opcode)
          OPW'(OP_LW), OPW'(OP_SW): state_d = S_MEMADDR;
          OPW'(OP_RTYPE):           state_d = S_EXEC_R;
          OPW'(OP_ADDI):            state_d = S_EXEC_I;
          OPW'(OP_BEQ):             state_d = S_BRANCH;
          OPW'(OP_J):               state_d = S_JUMP;
          OPW'(OP_HALT):            state_d = S_HALT;
          default:                  state_d = S_FAULT;
        endcase
      end
      S_MEMADDR:  state_d = (bus.Opcode == OPW'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
                  else if (timeout) state_d = S_FAULT;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
                  else if (timeout) state_d = S_FAULT;
      S_EXEC_R:   state_d = S_RWB;
      S_EXEC_I:   state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  // Counting only while staying in the same wait state also covers the clear-on-entry rule.
  always_comb begin
    wait_d = '0;
    if (in_wait && !bus.MemReady && (state_d == state_q)) wait_d = 8'(wait_q + 8'd1);
  end

  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_IWB) ||
             (state_q == S_BRANCH) || (state_q == S_JUMP) ||
             ((state_q == S_MEMWRITE) && bus.MemReady);
    ret_d  = retire ? CNT_W'(ret_q + 1'b1) : ret_q;
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = 2'b00;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.Halted      = 1'b0;
    bus.Fault       = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_DECODE:   bus.ALUSrcB = 2'b11;
      S_MEMADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.MemToReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_IWB:      bus.RegWrite = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_HALT:     bus.Halted = 1'b1;
      S_FAULT:    bus.Fault  = 1'b1;
      default: ;
    endcase
  end

  assign bus.State   = state_q;
  assign bus.Retired = ret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: an instruction-level model (per-opcode step plans, stall counting,
// retire-on-return-to-fetch) predicts state, controls and counters of two DUT instances.
module tb_multicycle_control_unit;
  localparam int OPW   = 4;
  localparam int CNT_W = 24;
  localparam int TO    = 16;
  localparam int NCYC  = 6000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op    = 4'd0;
  logic       mr    = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPW(OPW), .CNT_W(CNT_W)) ifa ();
  multicycle_control_unit_if #(.OPW(OPW), .CNT_W(4))     ifb ();

  assign ifa.Opcode   = op;
  assign ifa.MemReady = mr;
  assign ifb.Opcode   = op;
  assign ifb.MemReady = mr;

  multicycle_control_unit #(.OPW(OPW), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) u_dut (
    .Clock(clk), .Reset_n(rst_n), .bus(ifa)
  );
  multicycle_control_unit #(.OPW(OPW), .CNT_W(4), .MEM_TIMEOUT(TO)) u_dut4 (
    .Clock(clk), .Reset_n(rst_n), .bus(ifb)
  );

  logic [17:0] obs_a, obs_b;
  assign obs_a = {ifa.PCWrite, ifa.PCWriteCond, ifa.PCSource, ifa.IorD, ifa.MemRead,
                  ifa.MemWrite, ifa.IRWrite, ifa.RegDst, ifa.MemToReg, ifa.RegWrite,
                  ifa.ALUSrcA, ifa.ALUSrcB, ifa.ALUOp, ifa.Halted, ifa.Fault};
  assign obs_b = {ifb.PCWrite, ifb.PCWriteCond, ifb.PCSource, ifb.IorD, ifb.MemRead,
                  ifb.MemWrite, ifb.IRWrite, ifb.RegDst, ifb.MemToReg, ifb.RegWrite,
                  ifb.ALUSrcA, ifb.ALUSrcB, ifb.ALUOp, ifb.Halted, ifb.Fault};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_now  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_now, got, exp);
    end
  endtask

  // Control outputs per state, straight from the state descriptions.
  function automatic logic [17:0] exp_ctrl(input int s, input logic m);
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, hlt, flt;
    logic [1:0] psrc, sb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, hlt, flt} = '0;
    psrc = 2'b00; sb = 2'b00; aop = 2'b00;
    case (s)
      1:  begin mrd = 1; sb = 2'b01; irw = m; pcw = m; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin sa = 1; aop = 2'b10; end
      8:  begin rdst = 1; rw = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      12: begin pcw = 1; psrc = 2'b10; end
      13: hlt = 1;
      14: flt = 1;
      default: ;
    endcase
    return {pcw, pcwc, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, hlt, flt};
  endfunction

  int          m_state = 0;
  int          m_stall = 0;
  int unsigned m_ret   = 0;
  int          plan[$];
  bit          valid   = 0;

  function automatic bit is_wait(input int s);
    return (s == 1) || (s == 4) || (s == 6);
  endfunction

  task automatic model_step();
    int ns;
    if (!rst_n) begin
      m_state = 0; m_stall = 0; m_ret = 0; plan.delete();
      return;
    end
    ns = m_state;
    if (m_state == 0) ns = 1;
    else if (m_state == 13 || m_state == 14) ns = m_state;
    else if (m_state == 2) begin
      case (op)
        4'd0:    plan = '{7, 8};
        4'd1:    plan = '{9, 10};
        4'd2:    plan = '{3, 4, 5};
        4'd3:    plan = '{3, 6};
        4'd4:    plan = '{11};
        4'd5:    plan = '{12};
        4'd15:   plan = '{13};
        default: plan = '{14};
      endcase
      ns = plan.pop_front();
    end else if (is_wait(m_state) && !mr) begin
      if (m_stall == TO - 1) ns = 14;
    end else if (m_state == 1) ns = 2;
    else ns = (plan.size() > 0) ? plan.pop_front() : 1;

    if (ns == 1 && m_state != 1 && m_state != 0) m_ret++;
    if (ns == m_state && is_wait(m_state) && !mr) m_stall++;
    else m_stall = 0;
    m_state = ns;
  endtask

  initial begin
    int prev_state = -1;
    int target     = 0;
    int sink_cnt   = 0;
    int sink_hold  = 105;
    bit phase2;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      phase2  = (cyc >= 1500);
      if (m_state != prev_state) begin
        prev_state = m_state;
        if (!phase2 || $urandom_range(0, 9) < 7) target = $urandom_range(0, 3);
        else target = $urandom_range(12, 17);
      end
      mr = is_wait(m_state) ? (m_stall >= target) : 1'($urandom_range(0, 1));
      if (m_state == 1) begin
        if (!phase2) op = 4'($urandom_range(0, 5));
        else begin
          int r = $urandom_range(0, 99);
          if (r < 88)      op = 4'($urandom_range(0, 5));
          else if (r < 94) op = 4'd15;
          else             op = 4'($urandom_range(6, 14));
        end
      end
      if (m_state == 13 || m_state == 14) sink_cnt++;
      else sink_cnt = 0;
      if (cyc < 2) rst_n = 1'b0;
      else if (sink_cnt > sink_hold) begin
        rst_n     = 1'b0;
        sink_cnt  = 0;
        sink_hold = $urandom_range(1, 6);
      end else if (phase2 && $urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      #1;
      if (valid) begin
        check("state",    32'(ifa.State), 32'(m_state));
        check("ctrl",     32'(obs_a), 32'(exp_ctrl(m_state, mr)));
        check("retired",  32'(ifa.Retired), 32'(m_ret & 32'h00FF_FFFF));
        check("state4",   32'(ifb.State), 32'(m_state));
        check("ctrl4",    32'(obs_b), 32'(exp_ctrl(m_state, mr)));
        check("retired4", 32'(ifb.Retired), 32'(m_ret % 16));
      end
      model_step();
      valid = 1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation control unit that replaces the single-cycle combinational decoder with a multi-cycle Moore FSM.
- Sequences fetch, decode, execute, memory and writeback over several cycles and drives the multi-cycle datapath's mux, enable and ALU selects.
- Handles a variable-latency memory through a MemReady handshake with a wait-state timeout.
- Adds a halt state, an illegal-opcode fault and a retired-instruction counter.

Parameters:
- OPW, 4, opcode width
- CNT_W, 24, width of the retired-instruction counter
- MEM_TIMEOUT, 16, maximum wait cycles for MemReady before Fault; legal range 2..255
- OP_RTYPE, 0, R-type ALU opcode
- OP_ADDI, 1, immediate ALU opcode
- OP_LW, 2, load opcode
- OP_SW, 3, store opcode
- OP_BEQ, 4, branch-if-equal opcode
- OP_J, 5, jump opcode
- OP_HALT, 15, halt opcode

Ports:
- Clock  in  1  system clock; all state updates on the rising edge
- Reset_n  in  1  synchronous, active-low reset
- Opcode  in  OPW  opcode field from the instruction register
- MemReady  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero in the datapath
- PCSource  out  2  PC source select: 00 ALU, 01 ALUOut, 10 jump target
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination register select: 1 rd, 0 rt
- MemToReg  out  1  writeback data select: 1 MDR, 0 ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 PC, 1 register A
- ALUSrcB  out  2  ALU B select: 00 register B, 01 constant 1, 10 sign-extended immediate, 11 branch offset
- ALUOp  out  2  ALU operation class: 00 add, 01 subtract, 10 funct-decoded
- State  out  4  current state encoding, for debug
- Halted  out  1  sticky; set in HALT
- Fault  out  1  sticky; set in FAULT
- Retired  out  CNT_W  count of completed instructions

Behaviour:
- Moore machine: all control outputs are a pure function of the registered state, except IRWrite and PCWrite in FETCH, which equal MemReady.
- Any output not listed for a state is 0 in that state.
- Reset: when Reset_n=0 at an edge, the next state is IDLE, WaitCnt=0 and Retired=0. All outputs are 0 and State=0. Reset has priority over every transition, including in the middle of a memory wait.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXEC_R=7, RWB=8, EXEC_I=9, IWB=10, BRANCH=11, JUMP=12, HALT=13, FAULT=14.
- IDLE: go to FETCH unconditionally.
- FETCH:
  - Outputs MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Go to DECODE when MemReady=1; otherwise stay.
- DECODE:
  - Outputs ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by Opcode: LW or SW to MEMADDR, RTYPE to EXEC_R, ADDI to EXEC_I, BEQ to BRANCH, J to JUMP, HALT to HALT.
  - Any other opcode goes to FAULT.
- MEMADDR:
  - Outputs ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Go to MEMREAD if Opcode=LW, otherwise to MEMWRITE.
- MEMREAD: outputs MemRead=1, IorD=1; go to MEMWB when MemReady=1.
- MEMWB: outputs RegDst=0, MemToReg=1, RegWrite=1; go to FETCH.
- MEMWRITE: outputs MemWrite=1, IorD=1; go to FETCH when MemReady=1.
- EXEC_R: outputs ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to RWB.
- RWB: outputs RegDst=1, MemToReg=0, RegWrite=1; go to FETCH.
- EXEC_I: outputs ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to IWB.
- IWB: outputs RegDst=0, MemToReg=0, RegWrite=1; go to FETCH.
- BRANCH: outputs ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; go to FETCH.
- JUMP: outputs PCWrite=1, PCSource=10; go to FETCH.
- HALT: Halted=1; stays in HALT until reset.
- FAULT: Fault=1; stays in FAULT until reset.
- Wait states (FETCH, MEMREAD, MEMWRITE):
  - WaitCnt is 8 bits, cleared on entry to any wait state and when MemReady=1.
  - WaitCnt increments on each cycle spent in a wait state with MemReady=0.
  - If MemReady=0 while WaitCnt=MEM_TIMEOUT-1, go to FAULT. This is the MEM_TIMEOUT-th consecutive not-ready cycle.
  - MemReady=1 on that same cycle takes priority over the timeout.
  - MemRead or MemWrite stays asserted for the whole wait.
- Retired increments by 1 on the cycle that leaves MEMWB, RWB, IWB, BRANCH or JUMP, and on the cycle that MEMWRITE completes with MemReady=1.
- Retired wraps modulo 2^CNT_W. HALT does not count.
- Latency in cycles, assuming MemReady is already 1:
  - R-type, ADDI, LW: 4 (LW 5)
  - SW: 4
  - BEQ, J: 3
- MemReady is ignored outside wait states.

Test Plan:
- Hold Reset_n=0 for 2 cycles, then release with MemReady=1 and Opcode=0 → State sequence 0,1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8. Retired=1 after state 8.
- Opcode=2 with MemReady low for 3 cycles in FETCH and 2 cycles in MEMREAD → IRWrite and PCWrite pulse exactly once, in the cycle MemReady=1. State path 1,2,3,4,5. MemToReg=1 in state 5.
- Opcode=4, then Opcode=5 → BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01. JUMP shows PCWrite=1, PCSource=10. Retired increases by 2.
- MEM_TIMEOUT=16 with MemReady held 0 in FETCH → State=14 and Fault=1 after exactly 16 FETCH cycles. Fault holds until Reset_n=0. With MemReady=1 on the 16th cycle, the FSM goes to DECODE instead.
- Opcode=7 → FAULT. Opcode=15 → HALT, Halted=1, outputs stay constant for 100 cycles.
- Assert Reset_n=0 during a MEMWRITE wait → next state is IDLE, MemWrite=0, Retired=0. With CNT_W=4, retiring 17 instructions gives Retired=1.
